// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM word, RAM handshake status and arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } arb_state_t;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of dcache grants issued while the icache is kept waiting.
module arb_starve_ctr
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] count_reg, count_next;

  // inc and clr are never both asserted by the arbiter; clr wins regardless.
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg < LIMIT)) begin
      count_next = count_reg + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign sat = (count_reg == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for the icache/dcache pair: dcache has fixed priority,
// grants are held until ACCESS, and a starvation counter bounds icache latency.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  arb_state_t state_reg, state_next;

  logic sat;
  logic force_i;
  logic ctr_inc;
  logic ctr_clr;
  logic access;
  logic igrant;
  logic rgrant;
  logic wgrant;
  logic done_i;
  logic done_d;

  assign force_i = sat & iREN;
  assign access  = (ramstate == ACCESS);

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (dWEN && !force_i) begin
          state_next = DWRITE;
        end else if (dREN && !force_i) begin
          state_next = DREAD;
        end else if (iREN) begin
          state_next = IFETCH;
        end
      end
      // A grant ends on completion or when its requester withdraws.
      IFETCH: if (!iREN || access) state_next = IDLE;
      DREAD:  if (!dREN || access) state_next = IDLE;
      DWRITE: if (!dWEN || access) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign ctr_inc = (state_reg == IDLE) && iREN &&
                   ((state_next == DREAD) || (state_next == DWRITE));
  assign ctr_clr = (state_reg == IDLE) && (!iREN || (state_next == IFETCH));

  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk  (CLK),
    .rst_n(nRST),
    .inc  (ctr_inc),
    .clr  (ctr_clr),
    .sat  (sat)
  );

  // RAM side is live only while the granted requester still asserts its request.
  assign igrant = (state_reg == IFETCH) && iREN;
  assign rgrant = (state_reg == DREAD)  && dREN;
  assign wgrant = (state_reg == DWRITE) && dWEN;

  assign done_i = igrant & access;
  assign done_d = (rgrant | wgrant) & access;

  always_comb begin
    ramREN   = igrant | rgrant;
    ramWEN   = wgrant;
    ramaddr  = '0;
    ramstore = '0;
    if (igrant) begin
      ramaddr = iaddr;
    end else if (rgrant || wgrant) begin
      ramaddr = daddr;
    end
    if (wgrant) begin
      ramstore = dstore;
    end
  end

  assign iwait = iREN & ~done_i;
  assign dwait = (dREN | dWEN) & ~done_d;
  assign iload = done_i ? ramload : '0;
  assign dload = (rgrant && access) ? ramload : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised + directed bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LIMIT = 4;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      iwait, dwait, ramREN, ramWEN;
  word_t     iload, dload, ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // RAM model: sparse memory, per-access latency, optional ERROR cycles.
  word_t mem [word_t];
  int    mem_ver = 0;
  int    fixed_lat = 0;
  int    rand_lat = 0;
  int    busy_cnt = 0;
  int    cur_lat;
  bit    err_inj = 0;

  function automatic word_t memval(input word_t a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  assign cur_lat  = (fixed_lat >= 0) ? fixed_lat : rand_lat;
  assign ramstate = !(ramREN || ramWEN) ? FREE :
                    (busy_cnt >= cur_lat) ? ACCESS :
                    (err_inj && fixed_lat < 0) ? ERROR : BUSY;

  always @(ramaddr, mem_ver) ramload = memval(ramaddr);

  always @(posedge CLK) begin
    if (ramREN || ramWEN) begin
      if (ramstate == ACCESS) begin
        busy_cnt <= 0;
        rand_lat <= int'($urandom_range(0, 3));
        if (ramWEN) begin
          mem[ramaddr] = ramstore;
          mem_ver++;
        end
      end else begin
        busy_cnt <= busy_cnt + 1;
      end
    end else begin
      busy_cnt <= 0;
    end
    err_inj <= ($urandom % 8 == 0);
  end

  // Reference model: who owns the RAM (0 none, 1 icache, 2 dread, 3 dwrite)
  // and how many dcache grants the icache has sat through.
  int   m_owner, m_starve;
  logic m_active;

  assign m_active = (m_owner == 1 && iREN) || (m_owner == 2 && dREN) ||
                    (m_owner == 3 && dWEN);

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_owner  <= 0;
      m_starve <= 0;
    end else if (m_owner == 0) begin
      if (iREN && m_starve == LIMIT) begin
        m_owner  <= 1;
        m_starve <= 0;
      end else if (dWEN || dREN) begin
        m_owner  <= dWEN ? 3 : 2;
        m_starve <= !iREN ? 0 : (m_starve < LIMIT ? m_starve + 1 : LIMIT);
      end else if (iREN) begin
        m_owner  <= 1;
        m_starve <= 0;
      end else begin
        m_starve <= 0;
      end
    end else if (!m_active || ramstate == ACCESS) begin
      m_owner <= 0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    if (nRST) begin
      logic  igr, rgr, wgr, acc;
      word_t e_addr;
      igr = (m_owner == 1) && iREN;
      rgr = (m_owner == 2) && dREN;
      wgr = (m_owner == 3) && dWEN;
      acc = (ramstate == ACCESS);
      e_addr = igr ? iaddr : ((rgr || wgr) ? daddr : 32'h0);
      chk("ramREN",   32'(ramREN), 32'(igr || rgr));
      chk("ramWEN",   32'(ramWEN), 32'(wgr));
      chk("ramaddr",  ramaddr, e_addr);
      chk("ramstore", ramstore, wgr ? dstore : 32'h0);
      chk("iwait",    32'(iwait), 32'(iREN && !(igr && acc)));
      chk("dwait",    32'(dwait), 32'((dREN || dWEN) && !((rgr || wgr) && acc)));
      chk("iload",    iload, (igr && acc) ? memval(iaddr) : 32'h0);
      chk("dload",    dload, (rgr && acc) ? memval(daddr) : 32'h0);
      chk("starve_ctr", 32'(dut.u_starve.count_reg), 32'(m_starve));
    end
  end

  bit i_done_prev = 0, d_done_prev = 0;
  always @(negedge CLK) begin
    i_done_prev = iREN && !iwait;
    d_done_prev = (dREN || dWEN) && !dwait;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ramREN"},   32'(ramREN), 32'h0);
    chk({tag, "_ramWEN"},   32'(ramWEN), 32'h0);
    chk({tag, "_ramaddr"},  ramaddr, 32'h0);
    chk({tag, "_ramstore"}, ramstore, 32'h0);
    chk({tag, "_iwait"},    32'(iwait), 32'h0);
    chk({tag, "_dwait"},    32'(dwait), 32'h0);
    chk({tag, "_iload"},    iload, 32'h0);
    chk({tag, "_dload"},    dload, 32'h0);
  endtask

  initial begin
    int dgr;
    bit done;
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    mem[32'h40]  = 32'h2400_0001;
    mem[32'h100] = 32'h1234_5678;

    // Reset with no requests.
    mid(); mid();
    chk_idle_outputs("rst");
    chk("rst_state", 32'(dut.state_reg), 32'(IDLE));
    @(posedge CLK); #1 nRST = 1'b1;
    mid();
    chk_idle_outputs("idle");

    // Zero-latency ifetch.
    tick(); iREN = 1; iaddr = 32'h40;
    mid(); chk("if_c0_iwait", 32'(iwait), 32'h1);
    tick(); mid();
    chk("if_c1_ramREN", 32'(ramREN), 32'h1);
    chk("if_c1_ramaddr", ramaddr, 32'h40);
    chk("if_c1_iwait", 32'(iwait), 32'h0);
    chk("if_c1_iload", iload, 32'h2400_0001);
    tick(); iREN = 0;
    mid(); chk("if_c2_state", 32'(dut.state_reg), 32'(IDLE));

    // Simultaneous requests: write wins, icache waits.
    tick(); iREN = 1; iaddr = 32'h44; dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
    mid(); chk("all_c0_iwait", 32'(iwait), 32'h1);
    tick(); mid();
    chk("all_c1_ramWEN", 32'(ramWEN), 32'h1);
    chk("all_c1_ramREN", 32'(ramREN), 32'h0);
    chk("all_c1_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("all_c1_dwait", 32'(dwait), 32'h0);
    chk("all_c1_iwait", 32'(iwait), 32'h1);
    tick(); dREN = 0; dWEN = 0;
    mid(); chk("all_c2_iwait", 32'(iwait), 32'h1);
    tick(); mid();
    chk("all_c3_iwait", 32'(iwait), 32'h0);
    chk("all_c3_mem", memval(32'h80), 32'hDEAD_BEEF);
    tick(); iREN = 0;
    mid();

    // Starvation guard: exactly LIMIT dcache grants, then the icache.
    tick(); iREN = 1; iaddr = 32'h300; dREN = 1; daddr = 32'h200;
    dgr = 0; done = 0;
    for (int n = 0; n < 40; n++) begin
      mid();
      if (dREN && !dwait) dgr++;
      if (!iwait) begin
        done = 1;
        chk("starve_ctr_after", 32'(dut.u_starve.count_reg), 32'h0);
        chk("starve_model_after", 32'(m_starve), 32'h0);
        break;
      end
      tick();
    end
    chk("starve_done", 32'(done), 32'h1);
    chk("starve_grants", 32'(dgr), 32'(LIMIT));
    tick(); iREN = 0; dREN = 0;
    mid();

    // Latency-3 read.
    fixed_lat = 3;
    tick(); dREN = 1; daddr = 32'h100;
    mid();
    for (int k = 1; k <= 3; k++) begin
      tick(); mid();
      chk($sformatf("lat3_c%0d_dwait", k), 32'(dwait), 32'h1);
      chk($sformatf("lat3_c%0d_ramREN", k), 32'(ramREN), 32'h1);
    end
    tick(); mid();
    chk("lat3_c4_dwait", 32'(dwait), 32'h0);
    chk("lat3_c4_dload", dload, 32'h1234_5678);
    tick(); dREN = 0;
    mid();

    // Request withdrawn mid-grant, then a normal ifetch.
    tick(); dREN = 1; daddr = 32'h104;
    mid();
    tick(); mid(); chk("drop_c1_ramREN", 32'(ramREN), 32'h1);
    tick(); dREN = 0;
    mid();
    chk("drop_c2_ramREN", 32'(ramREN), 32'h0);
    chk("drop_c2_dwait", 32'(dwait), 32'h0);
    tick(); fixed_lat = 0; iREN = 1; iaddr = 32'h40;
    mid(); chk("drop_c3_state", 32'(dut.state_reg), 32'(IDLE));
    tick(); mid();
    chk("drop_c4_ramREN", 32'(ramREN), 32'h1);
    chk("drop_c4_iload", iload, 32'h2400_0001);
    tick(); iREN = 0;
    mid();

    // Asynchronous reset in the middle of a write.
    fixed_lat = 3;
    tick(); dWEN = 1; daddr = 32'h500; dstore = 32'h1111_2222;
    mid();
    tick(); mid(); chk("arst_pre_ramWEN", 32'(ramWEN), 32'h1);
    #2 nRST = 1'b0;
    #1;
    chk("arst_ramWEN", 32'(ramWEN), 32'h0);
    chk("arst_state", 32'(dut.state_reg), 32'(IDLE));
    chk("arst_ctr", 32'(dut.u_starve.count_reg), 32'h0);
    dWEN = 0;
    @(posedge CLK); #1 nRST = 1'b1;
    mid();
    chk_idle_outputs("arst_idle");

    // Random traffic with random latency and ERROR cycles.
    fixed_lat = -1;
    repeat (3000) begin
      tick();
      if (!iREN) begin
        if ($urandom % 3 == 0) begin iREN = 1; iaddr = {26'h0, 4'($urandom), 2'b00}; end
      end else if (i_done_prev) begin
        if ($urandom % 2 == 0) iaddr = {26'h0, 4'($urandom), 2'b00};
        else iREN = 0;
      end else if ($urandom % 40 == 0) begin
        iREN = 0;
      end
      if (!(dREN || dWEN)) begin
        if ($urandom % 3 == 0) begin
          int op;
          op = int'($urandom % 4);
          dWEN = (op <= 1);
          dREN = (op == 0) || (op >= 2);
          daddr = {26'h0, 4'($urandom), 2'b00};
          dstore = $urandom;
        end
      end else if (d_done_prev || ($urandom % 40 == 0)) begin
        dREN = 0; dWEN = 0;
      end
    end
    tick(); iREN = 0; dREN = 0; dWEN = 0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
